alu_gate_arbiter_rv32i: RTL and testbench

Shares one 32-bit logic unit (XOR/OR/AND) between NREQ requesters, e.g. the execute-stage ALU and a CSR/bit-manipulation sequencer. Arbitration is round-robin, with valid/ready handshakes on every requester port and on the single response port. The result is registered, so the block adds one cycle of latency and sustains one operation per cycle when there is no backpressure. It returns the winning requester ID with each result.

---
 rtl/alu_gate_arbiter_rv32i.sv | 97 +++++++++
 tb/tb_alu_gate_arbiter_rv32i.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_gate_arbiter_rv32i.sv
// Round-robin arbiter that shares one registered 32-bit XOR/OR/AND unit between NREQ requesters.
// Each result comes back one cycle after its grant, tagged with the winning requester ID.
module alu_gate_arbiter_rv32i #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_in1,
  input  logic [NREQ*32-1:0]   req_in2,
  input  logic [NREQ*3-1:0]    req_type,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_illegal
);

  localparam int DATA_W = 32;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

  // Returns {illegal, result}; unknown op codes produce a zero result.
  function automatic logic [DATA_W:0] logic_op(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [2:0]        op
  );
    logic [DATA_W:0] r;
    case (op)
      3'b000:  r = {1'b0, a ^ b};
      3'b001:  r = {1'b0, a | b};
      3'b010:  r = {1'b0, a & b};
      default: r = {1'b1, {DATA_W{1'b0}}};
    endcase
    return r;
  endfunction

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_idx_p0;
  logic               gnt_found_p0;
  logic               can_accept;
  logic               xfer_p0;
  logic [DATA_W-1:0]  op_a_p0;
  logic [DATA_W-1:0]  op_b_p0;
  logic [2:0]         op_type_p0;
  logic [DATA_W:0]    op_res_p0;

  // Stage 0: round-robin search starting at rr_ptr, grant, and operand mux
  always_comb begin
    gnt_found_p0 = 1'b0;
    gnt_idx_p0   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found_p0 && req_valid[ID_W'(idx)]) begin
        gnt_found_p0 = 1'b1;
        gnt_idx_p0   = ID_W'(idx);
      end
    end
  end

  assign can_accept = !rsp_valid || rsp_ready;
  assign xfer_p0    = !rst && can_accept && gnt_found_p0;

  always_comb begin
    req_ready = '0;
    if (xfer_p0) req_ready[gnt_idx_p0] = 1'b1;
  end

  assign op_a_p0    = req_in1[DATA_W*int'(gnt_idx_p0) +: DATA_W];
  assign op_b_p0    = req_in2[DATA_W*int'(gnt_idx_p0) +: DATA_W];
  assign op_type_p0 = req_type[3*int'(gnt_idx_p0) +: 3];
  assign op_res_p0  = logic_op(op_a_p0, op_b_p0, op_type_p0);

  // Stage 1: response register; a drain and a reload may happen on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      rsp_illegal <= 1'b0;
      rr_ptr      <= '0;
    end else if (xfer_p0) begin
      rsp_valid   <= 1'b1;
      rsp_data    <= op_res_p0[DATA_W-1:0];
      rsp_illegal <= op_res_p0[DATA_W];
      rsp_id      <= gnt_idx_p0;
      rr_ptr      <= (gnt_idx_p0 == LAST_ID) ? '0 : gnt_idx_p0 + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_gate_arbiter_rv32i.sv
// Scoreboard bench for alu_gate_arbiter_rv32i: the driver queues hand-computed responses,
// a monitor pops and compares them whenever a response handshake is presented.
module tb_alu_gate_arbiter_rv32i;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_in1;
  logic [NREQ*32-1:0]  req_in2;
  logic [NREQ*3-1:0]   req_type;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_data;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_illegal;

  typedef struct packed {
    logic [31:0]     data;
    logic [ID_W-1:0] id;
    logic            ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_gate_arbiter_rv32i #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .req_type    (req_type),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_illegal (rsp_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] t);
    req_in1[32*i +: 32] = a;
    req_in2[32*i +: 32] = b;
    req_type[3*i +: 3]  = t;
  endtask

  task automatic push(input logic [31:0] d, input logic [ID_W-1:0] id, input logic ill);
    exp_t e;
    e.data = d;
    e.id   = id;
    e.ill  = ill;
    exp_q.push_back(e);
  endtask

  // Monitor: a response transfers on the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual id=%0d data=0x%08h required=no response", rsp_id, rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_illegal", 32'(rsp_illegal), 32'(mon_e.ill));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_in1   = '0;
    req_in2   = '0;
    req_type  = '0;
    rsp_ready = 1'b1;

    // Reset held two cycles with every requester valid
    step();
    step();
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_valid", 32'(rsp_valid), 32'h0);
    check("reset_data", rsp_data, 32'h0);
    check("reset_id", 32'(rsp_id), 32'h0);
    step();
    rst = 1'b0;
    push(32'h0, 2'd0, 1'b0);
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'h1);
    step();

    // Single requester 2 through all three legal ops
    req_valid = 4'b0100;
    set_op(2, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b000);
    push(32'hFF00_EDCB, 2'd2, 1'b0);
    @(negedge clk);
    check("single_xor_ready", 32'(req_ready), 32'h4);
    step();
    set_op(2, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b001);
    push(32'hFFF0_FFFF, 2'd2, 1'b0);
    @(negedge clk);
    check("single_or_ready", 32'(req_ready), 32'h4);
    step();
    set_op(2, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'b010);
    push(32'h00F0_1234, 2'd2, 1'b0);
    @(negedge clk);
    check("single_and_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    step();

    // Re-centre the pointer at 0 before the fairness run
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Round-robin with all four valid
    set_op(0, 32'hC0DE_0000, 32'h0, 3'b000);
    set_op(1, 32'hC0DE_0001, 32'h0, 3'b000);
    set_op(2, 32'hC0DE_0002, 32'h0, 3'b000);
    set_op(3, 32'hC0DE_0003, 32'h0, 3'b000);
    req_valid = 4'b1111;
    push(32'hC0DE_0000, 2'd0, 1'b0);
    push(32'hC0DE_0001, 2'd1, 1'b0);
    push(32'hC0DE_0002, 2'd2, 1'b0);
    push(32'hC0DE_0003, 2'd3, 1'b0);
    push(32'hC0DE_0000, 2'd0, 1'b0);
    push(32'hC0DE_0001, 2'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) check("rr_valid", 32'(rsp_valid), 32'h1);
      step();
    end

    // Backpressure with requesters 1 and 3 waiting
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    set_op(1, 32'h1234_5678, 32'hFFFF_0000, 3'b010);
    set_op(3, 32'hAAAA_AAAA, 32'h5555_5555, 3'b001);
    push(32'hFFFF_FFFF, 2'd3, 1'b0);
    push(32'h1234_0000, 2'd1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 32'h0);
      check("bp_valid", 32'(rsp_valid), 32'h1);
      check("bp_data", rsp_data, 32'hC0DE_0001);
      check("bp_id", 32'(rsp_id), 32'h1);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'h8);
    step();
    @(negedge clk);
    check("bp_next_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    step();

    // Illegal type still consumed and advances the pointer
    req_valid = 4'b0001;
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101);
    push(32'h0, 2'd0, 1'b1);
    @(negedge clk);
    check("ill_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0011;
    set_op(1, 32'h0000_FFFF, 32'h00FF_00FF, 3'b000);
    push(32'h00FF_FF00, 2'd1, 1'b0);
    @(negedge clk);
    check("ill_next_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    step();

    // Reset while a result is stalled; it must be dropped
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    check("stall_valid", 32'(rsp_valid), 32'h1);
    check("stall_id", 32'(rsp_id), 32'h2);
    step();
    rst       = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    push(32'h0, 2'd0, 1'b1);
    @(negedge clk);
    check("post_rst_valid", 32'(rsp_valid), 32'h0);
    check("post_rst_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    @(negedge clk);
    step();
    step();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
